// File: rtl/rgb_mixer_n_if.sv
// Pad-side bundle for rgb_mixer_n: raw encoder inputs, PWM outputs, level readback
// and the pad output-enable-bar. NUM_CH/WIDTH must match the attached rgb_mixer_n.
interface rgb_mixer_n_if #(
    parameter int NUM_CH       = 3,
    parameter int WIDTH        = 8,
    parameter int MPRJ_IO_PADS = 38
);
    logic [NUM_CH-1:0]       enc_a;
    logic [NUM_CH-1:0]       enc_b;
    logic [NUM_CH-1:0]       pwm_out;
    logic [NUM_CH*WIDTH-1:0] level;
    logic [MPRJ_IO_PADS-1:0] io_oeb;

    modport master (
        output enc_a,
        output enc_b,
        input  pwm_out,
        input  level,
        input  io_oeb
    );

    modport slave (
        input  enc_a,
        input  enc_b,
        output pwm_out,
        output level,
        output io_oeb
    );
endinterface

// File: rtl/rgb_mixer_n.sv
// N-channel quadrature-encoder to PWM mixer: sync + debounce + step decode per channel,
// shared PWM counter with optional per-channel phase stagger and period-boundary duty latch.
module rgb_mixer_n #(
    parameter int NUM_CH   = 3,
    parameter int WIDTH    = 8,
    parameter int HIST_LEN = 8,
    parameter int STEP     = 1,
    parameter int SATURATE = 1,
    parameter int INIT     = 0,
    parameter int STAGGER  = 1
) (
    input  logic clk,
    input  logic reset,
    rgb_mixer_n_if.slave bus
);

    localparam int               OFF       = (STAGGER != 0) ? (2 ** WIDTH) / NUM_CH : 0;
    localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] INIT_L    = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] LEVEL_MAX = '1;

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.io_oeb = '0;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [WIDTH-1:0] PH_OFF = WIDTH'(gi * OFF);

            logic [1:0] raw_ab;
            logic [1:0] deb;   // [0] = A, [1] = B

            assign raw_ab = {bus.enc_b[gi], bus.enc_a[gi]};

            for (gj = 0; gj < 2; gj++) begin : g_deb
                logic [1:0]          sync_q;
                logic [HIST_LEN-1:0] hist_q;
                logic                deb_q;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        sync_q <= '0;
                        hist_q <= '0;
                        deb_q  <= 1'b0;
                    end else begin
                        sync_q <= {sync_q[0], raw_ab[gj]};
                        hist_q <= {hist_q[HIST_LEN-2:0], sync_q[1]};
                        // Hysteresis: only a fully uniform history moves the output.
                        if (&hist_q) begin
                            deb_q <= 1'b1;
                        end else if (~|hist_q) begin
                            deb_q <= 1'b0;
                        end
                    end
                end

                assign deb[gj] = deb_q;
            end

            logic             a_prev_q;
            logic [WIDTH-1:0] level_q;
            logic [WIDTH-1:0] level_d;
            logic [WIDTH-1:0] duty_q;
            logic [WIDTH-1:0] eff_d;
            logic [WIDTH-1:0] phase;
            logic [WIDTH:0]   sum_inc;
            logic [WIDTH:0]   sum_dec;
            logic             pwm_q;

            always_comb begin
                sum_inc = {1'b0, level_q} + STEP_W;
                sum_dec = {1'b0, level_q} - STEP_W;
                level_d = level_q;
                // Top bit of the WIDTH+1 result flags overflow (inc) or borrow (dec).
                if (deb[0] && !a_prev_q) begin
                    if (!deb[1]) begin
                        level_d = ((SATURATE != 0) && sum_inc[WIDTH]) ? LEVEL_MAX : sum_inc[WIDTH-1:0];
                    end else begin
                        level_d = ((SATURATE != 0) && sum_dec[WIDTH]) ? '0 : sum_dec[WIDTH-1:0];
                    end
                end
            end

            always_comb begin
                phase = cnt_q + PH_OFF;
                eff_d = (phase == '0) ? level_q : duty_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_prev_q <= 1'b0;
                    level_q  <= INIT_L;
                    duty_q   <= '0;
                    pwm_q    <= 1'b0;
                end else begin
                    a_prev_q <= deb[0];
                    level_q  <= level_d;
                    duty_q   <= eff_d;
                    pwm_q    <= (phase < eff_d);
                end
            end

            assign bus.pwm_out[gi]               = pwm_q;
            assign bus.level[gi*WIDTH +: WIDTH]  = level_q;
        end
    endgenerate

endmodule

// File: tb/tb_rgb_mixer_n.sv
// Directed bench: three rgb_mixer_n variants (saturating, wrapping/in-phase, STEP=16)
// share one encoder stimulus and are checked against hand-computed levels and PWM timing.
module tb_rgb_mixer_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] enc_a = 3'b000;
    logic [2:0] enc_b = 3'b000;
    logic [7:0] tb_cnt;
    int         vectors = 0;
    int         errors  = 0;

    always #5 clk = ~clk;

    // Bench time reference: cycles since reset release, modulo the 256-cycle period.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 8'd0;
        else     tb_cnt <= tb_cnt + 8'd1;
    end

    rgb_mixer_n_if #(.NUM_CH(3), .WIDTH(8)) if_s ();
    rgb_mixer_n_if #(.NUM_CH(3), .WIDTH(8)) if_w ();
    rgb_mixer_n_if #(.NUM_CH(3), .WIDTH(8)) if_16 ();

    assign if_s.enc_a  = enc_a;
    assign if_s.enc_b  = enc_b;
    assign if_w.enc_a  = enc_a;
    assign if_w.enc_b  = enc_b;
    assign if_16.enc_a = enc_a;
    assign if_16.enc_b = enc_b;

    rgb_mixer_n #(.NUM_CH(3), .WIDTH(8), .HIST_LEN(8), .STEP(1), .SATURATE(1), .INIT(0), .STAGGER(1))
        dut_s (.clk(clk), .reset(rst), .bus(if_s.slave));
    rgb_mixer_n #(.NUM_CH(3), .WIDTH(8), .HIST_LEN(8), .STEP(1), .SATURATE(0), .INIT(0), .STAGGER(0))
        dut_w (.clk(clk), .reset(rst), .bus(if_w.slave));
    rgb_mixer_n #(.NUM_CH(3), .WIDTH(8), .HIST_LEN(8), .STEP(16), .SATURATE(1), .INIT(0), .STAGGER(1))
        dut_16 (.clk(clk), .reset(rst), .bus(if_16.slave));

    function automatic logic pwm_of(input int d, input int c);
        case (d)
            0:       return if_s.pwm_out[c];
            1:       return if_w.pwm_out[c];
            default: return if_16.pwm_out[c];
        endcase
    endfunction

    function automatic logic [7:0] lvl(input int d, input int c);
        case (d)
            0:       return if_s.level[c*8 +: 8];
            1:       return if_w.level[c*8 +: 8];
            default: return if_16.level[c*8 +: 8];
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        enc_a = 3'b000;
        enc_b = 3'b000;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // One detent on the masked channels: B is held with A, so ccw=1 decrements.
    task automatic detent(input logic [2:0] mask, input logic ccw);
        enc_b = ccw ? mask : 3'b000;
        enc_a = mask;
        repeat (12) @(negedge clk);
        enc_a = 3'b000;
        enc_b = 3'b000;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_cnt(input logic [7:0] target);
        int k = 0;
        while (tb_cnt != target && k < 300) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Samples 256 consecutive cycles starting at the current negedge.
    task automatic measure_period(input int d, input int c, input logic [7:0] rise, input int len,
                                  output int highs, output int bad);
        logic [7:0] diff;
        logic       p;
        highs = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            diff = tb_cnt - rise;
            p    = pwm_of(d, c);
            highs += int'(p);
            if (p !== (int'(diff) < len)) bad++;
        end
    endtask

    task automatic test_reset();
        int highs;
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 3; c++) begin
                vectors++;
                if (lvl(d, c) !== 8'd0) begin
                    errors++;
                    $display("FAIL reset_async_level d%0d c%0d: got %0d want 0", d, c, lvl(d, c));
                end
            end
        end
        vectors++;
        if ({if_s.pwm_out, if_w.pwm_out, if_16.pwm_out} !== 9'd0) begin
            errors++;
            $display("FAIL reset_async_pwm: got %b want 0", {if_s.pwm_out, if_w.pwm_out, if_16.pwm_out});
        end
        repeat (10) begin
            @(negedge clk);
            enc_a = ~enc_a;
            enc_b = enc_a ^ 3'b101;
        end
        @(negedge clk);
        vectors++;
        if ({if_s.level, if_w.level, if_16.level} !== 72'd0 || {if_s.pwm_out, if_w.pwm_out, if_16.pwm_out} !== 9'd0) begin
            errors++;
            $display("FAIL reset_hold: got level %h pwm %b want all 0", if_s.level, if_s.pwm_out);
        end
        vectors++;
        if (if_s.io_oeb !== 38'd0 || if_w.io_oeb !== 38'd0 || if_16.io_oeb !== 38'd0) begin
            errors++;
            $display("FAIL reset_io_oeb: got %h want 0", if_s.io_oeb);
        end
        enc_a = 3'b000;
        enc_b = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        highs = 0;
        repeat (300) begin
            @(negedge clk);
            highs += $countones({if_s.pwm_out, if_w.pwm_out, if_16.pwm_out});
        end
        vectors++;
        if (highs !== 0) begin
            errors++;
            $display("FAIL post_reset_pwm_low: got %0d high samples want 0", highs);
        end
        vectors++;
        if (if_s.level !== 24'd0 || if_w.level !== 24'd0 || if_16.level !== 24'd0) begin
            errors++;
            $display("FAIL post_reset_level: got %h want 0", if_s.level);
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        @(negedge clk);
        enc_a = 3'b001;
        repeat (5) @(negedge clk);
        enc_a = 3'b000;
        repeat (20) @(negedge clk);
        vectors++;
        if (lvl(0, 0) !== 8'd0) begin
            errors++;
            $display("FAIL bounce_reject: got %0d want 0", lvl(0, 0));
        end
        enc_a = 3'b001;
        repeat (11) @(negedge clk);
        vectors++;
        if (lvl(0, 0) !== 8'd0) begin
            errors++;
            $display("FAIL bounce_early: got %0d want 0 at cycle 10", lvl(0, 0));
        end
        @(negedge clk);
        vectors++;
        if (lvl(0, 0) !== 8'd1) begin
            errors++;
            $display("FAIL bounce_latency: got %0d want 1 at cycle 11", lvl(0, 0));
        end
        repeat (8) @(negedge clk);
        enc_a = 3'b000;
        repeat (12) @(negedge clk);
        vectors++;
        if (lvl(0, 0) !== 8'd1) begin
            errors++;
            $display("FAIL bounce_single_step: got %0d want 1", lvl(0, 0));
        end
    endtask

    task automatic test_saturation();
        int h, b;
        apply_reset();
        repeat (256) detent(3'b010, 1'b0);
        vectors++;
        if (lvl(0, 1) !== 8'd255 || lvl(1, 1) !== 8'd0 || lvl(2, 1) !== 8'd255) begin
            errors++;
            $display("FAIL cw256: got s=%0d w=%0d s16=%0d want 255 0 255", lvl(0, 1), lvl(1, 1), lvl(2, 1));
        end
        repeat (44) detent(3'b010, 1'b0);
        vectors++;
        if (lvl(0, 1) !== 8'd255 || lvl(1, 1) !== 8'd44) begin
            errors++;
            $display("FAIL cw300: got s=%0d w=%0d want 255 44", lvl(0, 1), lvl(1, 1));
        end
        repeat (260) @(negedge clk);
        wait_cnt(8'd172);
        measure_period(0, 1, 8'd172, 255, h, b);
        vectors++;
        if (h !== 255 || b !== 0) begin
            errors++;
            $display("FAIL pwm_max: got %0d high %0d misplaced want 255 high 0 misplaced", h, b);
        end
        detent(3'b010, 1'b1);
        vectors++;
        if (lvl(0, 1) !== 8'd254 || lvl(1, 1) !== 8'd43 || lvl(2, 1) !== 8'd239) begin
            errors++;
            $display("FAIL ccw1: got s=%0d w=%0d s16=%0d want 254 43 239", lvl(0, 1), lvl(1, 1), lvl(2, 1));
        end
        detent(3'b100, 1'b1);
        vectors++;
        if (lvl(0, 2) !== 8'd0 || lvl(1, 2) !== 8'd255 || lvl(2, 2) !== 8'd0) begin
            errors++;
            $display("FAIL ccw_from0: got s=%0d w=%0d s16=%0d want 0 255 0", lvl(0, 2), lvl(1, 2), lvl(2, 2));
        end
        vectors++;
        if (lvl(0, 0) !== 8'd0 || lvl(1, 0) !== 8'd0) begin
            errors++;
            $display("FAIL ch0_independent: got s=%0d w=%0d want 0 0", lvl(0, 0), lvl(1, 0));
        end
    endtask

    task automatic test_step();
        apply_reset();
        repeat (3) detent(3'b001, 1'b0);
        vectors++;
        if (lvl(2, 0) !== 8'd48 || lvl(0, 0) !== 8'd3) begin
            errors++;
            $display("FAIL step_cw3: got s16=%0d s=%0d want 48 3", lvl(2, 0), lvl(0, 0));
        end
        repeat (4) detent(3'b001, 1'b1);
        vectors++;
        if (lvl(2, 0) !== 8'd0 || lvl(0, 0) !== 8'd0 || lvl(1, 0) !== 8'd255) begin
            errors++;
            $display("FAIL step_ccw4: got s16=%0d s=%0d w=%0d want 0 0 255", lvl(2, 0), lvl(0, 0), lvl(1, 0));
        end
    endtask

    task automatic test_pwm_update();
        int h, b;
        apply_reset();
        repeat (64) detent(3'b001, 1'b0);
        vectors++;
        if (lvl(0, 0) !== 8'd64) begin
            errors++;
            $display("FAIL pwm_level64: got %0d want 64", lvl(0, 0));
        end
        repeat (300) @(negedge clk);
        wait_cnt(8'd1);
        fork
            measure_period(0, 0, 8'd1, 64, h, b);
            begin
                repeat (20) @(negedge clk);
                detent(3'b001, 1'b0);
            end
        join
        vectors++;
        if (h !== 64 || b !== 0) begin
            errors++;
            $display("FAIL pwm_glitch_free: got %0d high %0d misplaced want 64 high 0 misplaced", h, b);
        end
        vectors++;
        if (lvl(0, 0) !== 8'd65) begin
            errors++;
            $display("FAIL pwm_level65: got %0d want 65", lvl(0, 0));
        end
        @(negedge clk);
        measure_period(0, 0, 8'd1, 65, h, b);
        vectors++;
        if (h !== 65 || b !== 0) begin
            errors++;
            $display("FAIL pwm_next_period: got %0d high %0d misplaced want 65 high 0 misplaced", h, b);
        end
    endtask

    task automatic test_stagger();
        int   rise [3][3];
        logic prev [3][3];
        logic cur;
        apply_reset();
        repeat (10) detent(3'b111, 1'b0);
        repeat (300) @(negedge clk);
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 3; c++) begin
                rise[d][c] = -1;
                prev[d][c] = pwm_of(d, c);
            end
        repeat (256) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++)
                for (int c = 0; c < 3; c++) begin
                    cur = pwm_of(d, c);
                    if (cur && !prev[d][c]) rise[d][c] = int'(tb_cnt);
                    prev[d][c] = cur;
                end
        end
        vectors++;
        if (rise[0][0] !== 1 || rise[0][1] !== 172 || rise[0][2] !== 87) begin
            errors++;
            $display("FAIL stagger_on: got rises %0d %0d %0d want 1 172 87", rise[0][0], rise[0][1], rise[0][2]);
        end
        vectors++;
        if (rise[1][0] !== 1 || rise[1][1] !== 1 || rise[1][2] !== 1) begin
            errors++;
            $display("FAIL stagger_off: got rises %0d %0d %0d want 1 1 1", rise[1][0], rise[1][1], rise[1][2]);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_saturation();
        test_step();
        test_pwm_update();
        test_stagger();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/rgb_mixer_n.md
# rgb_mixer_n

Parametrised N-channel successor to the three-channel encoder/PWM mixer. Each channel takes a raw quadrature encoder (a/b), synchronises and debounces it, decodes it into a level register with configurable step and saturate-or-wrap behaviour, and drives a PWM output. Duty updates are glitch-free because a new level is applied only at the channel's period boundary. Per-channel phase staggering spreads the PWM rising edges. Sits directly behind the user-project IO pads; levels are also exported for logic-analyser/wishbone readback.

## Interface
- NUM_CH, 3: number of encoder/PWM channels (1..8).
- WIDTH, 8: level and PWM counter width (4..12); PWM period = 2^WIDTH cycles.
- HIST_LEN, 8: debounce history length in samples (2..32).
- STEP, 1: level change per encoder detent (1..2^WIDTH-1).
- SATURATE, 1: 1 = clamp at 0 / 2^WIDTH-1; 0 = wrap modulo 2^WIDTH.
- INIT, 0: level value after reset.
- STAGGER, 1: 1 = channel i PWM phase offset by i*floor(2^WIDTH/NUM_CH); 0 = all channels in phase.
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- enc_a  in  NUM_CH  raw encoder A inputs; bit i belongs to channel i.
- enc_b  in  NUM_CH  raw encoder B inputs.
- pwm_out  out  NUM_CH  registered PWM outputs.
- level  out  NUM_CH*WIDTH  current level registers; channel i at [i*WIDTH +: WIDTH].
- io_oeb  out  MPRJ_IO_PADS  output-enable-bar, tied to all zeros.

## Operation
- Synchroniser: each raw enc_a/enc_b passes through 2 flops; reset value 0.
- Debounce (per signal): HIST_LEN-bit shift register of synchronised samples. Output goes 1 when all bits are 1, goes 0 when all bits are 0, and holds otherwise. History and output reset to 0.
- Decode (per channel): register previous debounced A. On a rising edge of debounced A: B=0 -> increment by STEP; B=1 -> decrement by STEP. Falling A edges and B edges alone do nothing. One edge changes the level by at most one step.
- Arithmetic: compute in WIDTH+1 bits.
  - SATURATE=1: an increment past 2^WIDTH-1 yields 2^WIDTH-1; a decrement below 0 yields 0.
  - SATURATE=0: the result is truncated to WIDTH bits (wrap).
- level resets to INIT[WIDTH-1:0].
- PWM counter: a single shared WIDTH-bit free-running counter, reset 0, +1 per cycle, wraps at 2^WIDTH-1 -> 0.
  - Channel phase p_i = (cnt + i*OFF) mod 2^WIDTH, where OFF = floor(2^WIDTH/NUM_CH) when STAGGER=1, else 0.
- Duty latch per channel:
  - eff_i = level_i when p_i==0, else duty_i.
  - Each cycle: duty_i <= eff_i and pwm_out[i] <= (p_i < eff_i).
  - duty_i resets to 0.
- Consequences:
  - level 0 -> output permanently low.
  - level L -> high for exactly L of every 2^WIDTH cycles, contiguous, starting on the cycle after p_i==0.
  - Maximum level -> low 1 cycle per period.
- Level changes mid-period never alter the current period's duty.
- io_oeb is constant 0, including during reset.

## Timing
- Reset (async assert, sync release): pwm_out=0, level=INIT, all internal state 0, regardless of clock.
- Input-to-debounced latency: a raw change stable for HIST_LEN+2 cycles appears on the debounced signal HIST_LEN+2 cycles after the first sampling edge. Pulses shorter than HIST_LEN cycles are rejected.
- Debounced-A rise -> level update: 1 cycle later.
- level -> PWM: takes effect at the next p_i==0. The first affected pwm_out high appears 1 cycle after that. Worst case is 2^WIDTH cycles.
- Simultaneous events:
  - A level change in the same cycle as p_i==0: the pre-change level is latched, because level is a register updated at the same edge.
  - Channels are fully independent.
- Reset mid-period: the counter restarts at 0. The first period after release uses INIT for channel 0, and for other channels at their first p_i==0.

## Test plan
- Reset: defaults, INIT=0; hold reset, toggle inputs -> pwm_out=0, level=0, io_oeb=0. Release -> cnt starts at 0 and all outputs stay low.
- Bounce rejection: enc_a[0] glitches high for 5 cycles with HIST_LEN=8 -> level unchanged. Then hold high for 20 cycles with B=0 -> level[7:0]=1 exactly 11 cycles after the first high sample.
- Direction and saturation: 300 CW detents on ch1 -> level=255 with SATURATE=1. Then 1 CCW detent -> 254. With SATURATE=0, 256 CW from 0 -> 0 and 1 CCW from 0 -> 255.
- STEP: STEP=16, 3 CW detents from 0 -> 48. Then 4 CCW detents -> 0, saturated.
- PWM duty and glitch-free update: set level 64 on ch0 -> pwm_out[0] high 64 consecutive cycles per 256. Change level to 200 mid-period -> the current period still has 64 high cycles and the next has 200. Level 0 -> never high; level 255 -> 255 high cycles.
- Stagger: NUM_CH=3, all levels 10, STAGGER=1 -> rising edges of ch1 and ch2 lead ch0 by 85 and 170 cycles, i.e. occur at cnt=172 and cnt=87. STAGGER=0 -> all three rise on the same cycle.
